quickq_seq_ctrl: RTL and testbench

QUICKQ_SEQ_CTRL -- requirements
Module: quickq_seq_ctrl

---
 rtl/quickq_seq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_quickq_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quickq_seq_ctrl.sv
// quickq_seq_ctrl: sorted priority queue held in an external single-port BRAM.
// Addresses 0..count-1 always hold keys in ascending unsigned order, so the
// minimum sits at address 0.
//
// Enqueue is an insertion pass that bubbles the larger key towards the tail:
// each visited entry is read, then overwritten with reg_key if reg_key is
// strictly smaller. The key still held at the end is appended at address count.
// Strict compare means equal keys keep their arrival order.
//
// Dequeue reads the head and returns it. It then shifts entries 1..count-1 down
// by one address.
//
// BRAM port signals are decoded combinationally from the state. The BRAM has a
// one-cycle read latency, so the data read in E_RD/D_SRD arrives in
// E_CMP/D_SWR. The write of that same cycle depends on it, so a registered
// strobe would land one cycle late and collide with the next read address.
module quickq_seq_ctrl #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enq_valid,
    input  logic [W-1:0]  enq_data,
    output logic          enq_ready,
    input  logic          deq_req,
    output logic          deq_valid,
    output logic [W-1:0]  deq_data,
    output logic [AW-1:0] bram_addr,
    output logic          bram_we,
    output logic [W-1:0]  bram_wdata,
    input  logic [W-1:0]  bram_rdata,
    output logic [AW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE,
        E_RD,
        E_CMP,
        E_TAIL,
        D_RD,
        D_HEAD,
        D_SRD,
        D_SWR
    } state_t;

    localparam logic [AW-1:0] DEPTH_C = AW'(DEPTH);
    localparam logic [AW-1:0] ONE     = AW'(1);

    state_t        state;
    logic [AW-1:0] idx;
    logic [W-1:0]  reg_key;

    logic [AW-1:0] last_idx;
    logic          idx_last;
    logic          swap;

    // Status flags and handshake derived from the stored count and state.
    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign busy      = (state != IDLE);
    assign enq_ready = (state == IDLE) && !full && !deq_req;

    // last_idx is only consulted in states reachable with count >= 1.
    assign last_idx = count - ONE;
    assign idx_last = (idx == last_idx);
    assign swap     = (reg_key < bram_rdata);

    // Sequencer: enqueue insertion pass, dequeue head read and shift-down, plus
    // the registered dequeue result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            idx       <= '0;
            reg_key   <= '0;
            deq_data  <= '0;
            deq_valid <= 1'b0;
        end else begin
            deq_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (deq_req && !empty) begin
                        state <= D_RD;
                    end else if (enq_valid && enq_ready) begin
                        reg_key <= enq_data;
                        idx     <= '0;
                        state   <= empty ? E_TAIL : E_RD;
                    end
                end

                E_RD: begin
                    state <= E_CMP;
                end

                E_CMP: begin
                    if (swap) begin
                        reg_key <= bram_rdata;
                    end
                    idx   <= idx + ONE;
                    state <= idx_last ? E_TAIL : E_RD;
                end

                E_TAIL: begin
                    if (!full) begin
                        count <= count + ONE;
                    end
                    state <= IDLE;
                end

                D_RD: begin
                    state <= D_HEAD;
                end

                D_HEAD: begin
                    deq_data  <= bram_rdata;
                    deq_valid <= 1'b1;
                    if (count == ONE) begin
                        count <= '0;
                        state <= IDLE;
                    end else begin
                        idx   <= ONE;
                        state <= D_SRD;
                    end
                end

                D_SRD: begin
                    state <= D_SWR;
                end

                D_SWR: begin
                    idx <= idx + ONE;
                    if (idx_last) begin
                        if (!empty) begin
                            count <= count - ONE;
                        end
                        state <= IDLE;
                    end else begin
                        state <= D_SRD;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // BRAM port decode. An asserted reset forces the port quiet so that an
    // aborted sequence never issues one more write.
    always_comb begin
        bram_addr  = '0;
        bram_we    = 1'b0;
        bram_wdata = '0;
        if (!rst) begin
            case (state)
                E_RD: begin
                    bram_addr = idx;
                end
                E_CMP: begin
                    bram_addr  = idx;
                    bram_we    = swap;
                    bram_wdata = reg_key;
                end
                E_TAIL: begin
                    bram_addr  = count;
                    bram_we    = 1'b1;
                    bram_wdata = reg_key;
                end
                D_SRD: begin
                    bram_addr = idx;
                end
                D_SWR: begin
                    bram_addr  = idx - ONE;
                    bram_we    = 1'b1;
                    bram_wdata = bram_rdata;
                end
                default: begin
                    bram_addr = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quickq_seq_ctrl.sv
// Bench for quickq_seq_ctrl with DEPTH=4 and a behavioural one-cycle-latency BRAM.
// The reference model is a sorted queue with stable insertion.
module tb_quickq_seq_ctrl;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          enq_valid;
    logic [W-1:0]  enq_data;
    logic          enq_ready;
    logic          deq_req;
    logic          deq_valid;
    logic [W-1:0]  deq_data;
    logic [AW-1:0] bram_addr;
    logic          bram_we;
    logic [W-1:0]  bram_wdata;
    logic [W-1:0]  bram_rdata;
    logic [AW-1:0] count;
    logic          full;
    logic          empty;
    logic          busy;

    logic [W-1:0]  mem [0:7];
    logic [W-1:0]  model [$];
    logic [W-1:0]  last_deq;
    int            tests = 0;
    int            fails = 0;

    always #5 clk = ~clk;

    quickq_seq_ctrl #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .enq_valid  (enq_valid),
        .enq_data   (enq_data),
        .enq_ready  (enq_ready),
        .deq_req    (deq_req),
        .deq_valid  (deq_valid),
        .deq_data   (deq_data),
        .bram_addr  (bram_addr),
        .bram_we    (bram_we),
        .bram_wdata (bram_wdata),
        .bram_rdata (bram_rdata),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .busy       (busy)
    );

    // Behavioural BRAM: synchronous write, registered read.
    always @(posedge clk) begin
        if (bram_we) mem[bram_addr] <= bram_wdata;
        bram_rdata <= mem[bram_addr];
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Idle-cycle checks of status outputs against the model.
    always @(negedge clk) begin
        if (!rst && !busy) begin
            chk("count", 32'(count), 32'(model.size()));
            chk("full", 32'(full), 32'(model.size() == DEPTH));
            chk("empty", 32'(empty), 32'(model.size() == 0));
            chk("enq_ready", 32'(enq_ready), 32'(model.size() < DEPTH && !deq_req));
            chk("deq_data_hold", deq_data, last_deq);
        end
    end

    task automatic check_mem();
        for (int j = 0; j < model.size(); j++) chk("bram_contents", mem[j], model[j]);
    endtask

    // Called one step after the accepting edge; counts busy cycles and updates the model.
    task automatic wait_enq(input logic [W-1:0] key);
        int c = model.size();
        int n = 0;
        int j = 0;
        if (c == 0) begin
            chk("tail_we", 32'(bram_we), 32'd1);
            chk("tail_addr", 32'(bram_addr), 32'd0);
        end
        while (busy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk("enq_busy_cycles", 32'(n), 32'(2 * c + 1));
        while (j < model.size() && model[j] <= key) j++;
        model.insert(j, key);
        check_mem();
    endtask

    task automatic do_enq(input logic [W-1:0] key);
        enq_valid = 1'b1;
        enq_data  = key;
        #0;
        chk("enq_ready_before_accept", 32'(enq_ready), 32'd1);
        @(posedge clk); #1;
        enq_valid = 1'b0;
        wait_enq(key);
    endtask

    // Called one step after the edge that started the dequeue.
    task automatic deq_body(output logic [W-1:0] d);
        int c = model.size();
        int n = 0;
        int seen = 0;
        d = '0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk); #1;
            if (deq_valid) begin
                seen++;
                d = deq_data;
            end
        end
        chk("deq_busy_cycles", 32'(n), 32'(2 * c));
        chk("deq_valid_pulses", 32'(seen), 32'd1);
        if (c > 0) begin
            chk("deq_data_model", d, model[0]);
            last_deq = model.pop_front();
        end
        check_mem();
    endtask

    task automatic do_deq(output logic [W-1:0] d);
        deq_req = 1'b1;
        @(posedge clk); #1;
        deq_req = 1'b0;
        deq_body(d);
    endtask

    initial begin
        logic [W-1:0] d;
        rst = 1'b1; enq_valid = 1'b0; enq_data = '0; deq_req = 1'b0; last_deq = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_bram_we", 32'(bram_we), 32'd0);
        chk("rst_bram_addr", 32'(bram_addr), 32'd0);
        rst = 1'b0;
        #0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_deq_valid", 32'(deq_valid), 32'd0);
        chk("rst_deq_data", deq_data, 32'd0);
        chk("enq_ready_after_rst", 32'(enq_ready), 32'd1);

        // Fill with a duplicate key; stable order keeps both 2s ahead of 5.
        do_enq(32'd5); do_enq(32'd2); do_enq(32'd9); do_enq(32'd2);
        chk("fill_mem0", mem[0], 32'd2);
        chk("fill_mem1", mem[1], 32'd2);
        chk("fill_mem2", mem[2], 32'd5);
        chk("fill_mem3", mem[3], 32'd9);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_full", 32'(full), 32'd1);
        enq_valid = 1'b1; enq_data = 32'd77;
        #0;
        chk("full_enq_ready", 32'(enq_ready), 32'd0);
        @(posedge clk); #1;
        chk("full_enq_ignored", 32'(busy), 32'd0);
        enq_valid = 1'b0;

        // Drain all four entries.
        do_deq(d); chk("deq1", d, 32'd2);
        do_deq(d); chk("deq2", d, 32'd2);
        do_deq(d); chk("deq3", d, 32'd5);
        do_deq(d); chk("deq4", d, 32'd9);
        chk("drained_empty", 32'(empty), 32'd1);

        // A dequeue request on an empty queue is ignored.
        deq_req = 1'b1;
        @(posedge clk); #1;
        deq_req = 1'b0;
        chk("empty_deq_busy", 32'(busy), 32'd0);
        chk("empty_deq_valid", 32'(deq_valid), 32'd0);
        @(posedge clk); #1;
        chk("empty_deq_valid_late", 32'(deq_valid), 32'd0);

        // Insert into an empty queue, then insert ahead of the existing entry.
        do_enq(32'd7);
        do_enq(32'd3);
        chk("two_mem0", mem[0], 32'd3);
        chk("two_mem1", mem[1], 32'd7);

        // Enqueue and dequeue requested together: dequeue wins, enqueue waits.
        enq_valid = 1'b1; enq_data = 32'd4; deq_req = 1'b1;
        #0;
        chk("collide_enq_ready", 32'(enq_ready), 32'd0);
        @(posedge clk); #1;
        deq_req = 1'b0;
        chk("collide_deq_started", 32'(busy), 32'd1);
        deq_body(d);
        chk("collide_deq_data", d, 32'd3);
        chk("collide_enq_ready_after", 32'(enq_ready), 32'd1);
        @(posedge clk); #1;
        enq_valid = 1'b0;
        wait_enq(32'd4);
        chk("collide_mem0", mem[0], 32'd4);
        chk("collide_mem1", mem[1], 32'd7);

        // Reset during E_CMP of the third enqueue.
        enq_valid = 1'b1; enq_data = 32'd5;
        @(posedge clk); #1;
        enq_valid = 1'b0;
        chk("abort_busy_erd", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #0;
        chk("abort_we_in_rst", 32'(bram_we), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model.delete();
        last_deq = '0;
        chk("abort_count", 32'(count), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_bram_we", 32'(bram_we), 32'd0);
        do_enq(32'd1);
        chk("abort_mem0", mem[0], 32'd1);

        // Full-width unsigned compare.
        do_enq(32'hFFFF_FFFF);
        do_enq(32'd0);
        chk("unsigned_mem0", mem[0], 32'd0);
        chk("unsigned_mem1", mem[1], 32'd1);
        chk("unsigned_mem2", mem[2], 32'hFFFF_FFFF);
        do_deq(d); chk("unsigned_deq1", d, 32'd0);
        do_deq(d); chk("unsigned_deq2", d, 32'd1);
        do_deq(d); chk("unsigned_deq3", d, 32'hFFFF_FFFF);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
